// File: rtl/mux_arb_pkg.sv
// Shared constants and helpers for the N-to-1 arbitrated channel selector.
package mux_arb_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/mux_arb_nx1_rr_pick.sv
// Rotated priority encoder: first requester after ptr, wrapping modulo N.
module rr_pick #(
    parameter int N  = 8,
    parameter int SW = 3
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [SW-1:0] gnt_idx,
    output logic          gnt_any
);

    // Scan offsets from farthest to nearest so the nearest requester overwrites.
    always_comb begin
        gnt_idx = '0;
        for (int k = N; k >= 1; k--) begin
            for (int i = 0; i < N; i++) begin
                if (req[i] && (i == ((int'(ptr) + k) % N))) begin
                    gnt_idx = SW'(i);
                end
            end
        end
    end

    assign gnt_any = |req;

endmodule

// File: rtl/mux_arb_nx1.sv
// N-to-1 channel selector with fixed or round-robin grant and a one-entry
// registered output stage using valid/ready handshakes.
module mux_arb_nx1
    import mux_arb_pkg::*;
#(
    parameter int  W  = 4,
    parameter int  N  = 8,
    localparam int SW = clog2(N)
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [N*W-1:0]  A,
    input  logic [N-1:0]    A_VALID,
    output logic [N-1:0]    A_READY,
    input  logic            MODE,
    input  logic [SW-1:0]   S,
    output logic [W-1:0]    OUT,
    output logic            OUT_VALID,
    input  logic            OUT_READY,
    output logic [SW-1:0]   OUT_SEL
);

    logic [W-1:0]  out_q, out_d;
    logic          out_valid_q, out_valid_d;
    logic [SW-1:0] out_sel_q, out_sel_d;
    logic [SW-1:0] ptr_q, ptr_d;

    logic [SW-1:0] rr_idx;
    logic          rr_any;
    logic          fix_hit;
    logic [SW-1:0] grant;
    logic          gvalid;
    logic          load_en;
    logic          xfer;
    logic [W-1:0]  gnt_data;

    rr_pick #(
        .N  (N),
        .SW (SW)
    ) u_rr_pick (
        .req     (A_VALID),
        .ptr     (ptr_q),
        .gnt_idx (rr_idx),
        .gnt_any (rr_any)
    );

    // An out-of-range S matches no channel, so fix_hit stays low.
    always_comb begin
        fix_hit = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (S == SW'(i)) fix_hit = A_VALID[i];
        end
        grant  = rr_idx;
        gvalid = rr_any;
        case (MODE)
            MODE_FIXED: begin
                grant  = S;
                gvalid = fix_hit;
            end
            MODE_RR: begin
                grant  = rr_idx;
                gvalid = rr_any;
            end
            default: ;
        endcase
    end

    assign load_en = !out_valid_q || OUT_READY;
    assign xfer    = load_en && gvalid && !RST;

    always_comb begin
        A_READY  = '0;
        gnt_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant == SW'(i)) begin
                A_READY[i] = xfer;
                gnt_data   = A[i*W +: W];
            end
        end
    end

    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
        if (xfer) begin
            out_d       = gnt_data;
            out_valid_d = 1'b1;
            out_sel_d   = grant;
            ptr_d       = grant;
        end else if (OUT_READY) begin
            out_valid_d = 1'b0;
        end
    end

    // PTR resets to N-1 so channel 0 wins the first round-robin search.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            out_sel_q   <= '0;
            ptr_q       <= SW'(N - 1);
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

    assign OUT       = out_q;
    assign OUT_VALID = out_valid_q;
    assign OUT_SEL   = out_sel_q;

endmodule

// File: tb/tb_mux_arb_nx1.sv
// Self-checking bench for mux_arb_nx1: directed plan scenarios plus random traffic.
module tb_mux_arb_nx1;

    localparam int W  = 4;
    localparam int N  = 8;
    localparam int SW = 3;
    localparam int N5 = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*W-1:0]  a;
    logic [N-1:0]    a_valid;
    logic [N-1:0]    a_ready;
    logic            mode;
    logic [SW-1:0]   s;
    logic [W-1:0]    out;
    logic            out_valid;
    logic            out_ready;
    logic [SW-1:0]   out_sel;

    logic [N5*W-1:0] a5;
    logic [N5-1:0]   av5;
    logic [N5-1:0]   ar5;
    logic            mode5;
    logic [2:0]      s5;
    logic [W-1:0]    out5;
    logic            ov5;
    logic            ordy5;
    logic [2:0]      os5;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    logic [W-1:0] m_out;
    bit           m_vld;
    int           m_sel;
    int           m_ptr;

    always #5 clk = ~clk;

    mux_arb_nx1 #(.W(W), .N(N)) dut (
        .CLK(clk), .RST(rst), .A(a), .A_VALID(a_valid), .A_READY(a_ready),
        .MODE(mode), .S(s), .OUT(out), .OUT_VALID(out_valid),
        .OUT_READY(out_ready), .OUT_SEL(out_sel)
    );

    mux_arb_nx1 #(.W(W), .N(N5)) dut5 (
        .CLK(clk), .RST(rst), .A(a5), .A_VALID(av5), .A_READY(ar5),
        .MODE(mode5), .S(s5), .OUT(out5), .OUT_VALID(ov5),
        .OUT_READY(ordy5), .OUT_SEL(os5)
    );

    function automatic void model_grant(output int g, output bit gv);
        g  = 0;
        gv = 1'b0;
        if (mode == 1'b0) begin
            if (int'(s) < N) begin
                g  = int'(s);
                gv = a_valid[g];
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (!gv && a_valid[j]) begin
                    g  = j;
                    gv = 1'b1;
                end
            end
        end
    endfunction

    function automatic logic [N-1:0] exp_ready();
        int g;
        bit gv;
        model_grant(g, gv);
        exp_ready = '0;
        if ((!m_vld || out_ready) && gv) exp_ready[g] = 1'b1;
    endfunction

    task automatic model_reset();
        m_out = '0;
        m_vld = 1'b0;
        m_sel = 0;
        m_ptr = N - 1;
    endtask

    task automatic step();
        int           g;
        bit           gv;
        bit           le;
        logic [W-1:0] d;
        model_grant(g, gv);
        le = !m_vld || out_ready;
        d  = a[g*W +: W];
        @(posedge clk);
        if (le && gv) begin
            m_out = d;
            m_sel = g;
            m_vld = 1'b1;
            m_ptr = g;
        end else if (m_vld && out_ready) begin
            m_vld = 1'b0;
        end
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #4;
        rst = 1'b0;
        model_reset();
        #1;
    endtask

    task automatic set_counting_data();
        for (int i = 0; i < N; i++) a[i*W +: W] = W'(i + 1);
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        mode      = 1'b1;
        a_valid   = '1;
        out_ready = 1'b1;
        #1;
        chk_cnt++;
        if (a_ready !== 8'h00) $display("FAIL reset_a_ready: got %b want %b", a_ready, 8'h00);
        else pass_cnt++;
        chk_cnt++;
        if (out !== 4'h0 || out_valid !== 1'b0 || out_sel !== 3'd0)
            $display("FAIL reset_outputs: got out=%h vld=%b sel=%0d want 0/0/0", out, out_valid, out_sel);
        else pass_cnt++;
        apply_reset();
        chk_cnt++;
        if (a_ready !== 8'h01) $display("FAIL reset_first_rr_grant: got %b want %b", a_ready, 8'h01);
        else pass_cnt++;
    endtask

    task automatic test_fixed_sweep();
        apply_reset();
        set_counting_data();
        a_valid   = '1;
        out_ready = 1'b1;
        mode      = 1'b0;
        for (int t = 0; t < N; t++) begin
            logic [N-1:0] oh;
            s  = SW'(t);
            oh = '0;
            oh[t] = 1'b1;
            #3;
            chk_cnt++;
            if (a_ready !== oh) $display("FAIL fixed_a_ready[%0d]: got %b want %b", t, a_ready, oh);
            else pass_cnt++;
            step();
            chk_cnt++;
            if (out !== W'(t + 1) || out_sel !== SW'(t) || out_valid !== 1'b1)
                $display("FAIL fixed_out[%0d]: got out=%h sel=%0d vld=%b want %h/%0d/1",
                         t, out, out_sel, out_valid, W'(t + 1), t);
            else pass_cnt++;
        end
    endtask

    task automatic test_rr_fairness();
        int sel_exp [8] = '{0, 2, 5, 7, 0, 2, 5, 7};
        int out_exp [8] = '{1, 3, 6, 8, 1, 3, 6, 8};
        apply_reset();
        set_counting_data();
        mode      = 1'b1;
        a_valid   = 8'b1010_0101;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            chk_cnt++;
            if (out_sel !== SW'(sel_exp[k]) || out !== W'(out_exp[k]))
                $display("FAIL rr_seq[%0d]: got sel=%0d out=%h want sel=%0d out=%h",
                         k, out_sel, out, sel_exp[k], out_exp[k]);
            else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        set_counting_data();
        mode      = 1'b0;
        s         = 3'd2;
        a_valid   = '1;
        out_ready = 1'b1;
        step();
        s         = 3'd4;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #3;
            chk_cnt++;
            if (a_ready !== 8'h00) $display("FAIL bp_a_ready[%0d]: got %b want %b", k, a_ready, 8'h00);
            else pass_cnt++;
            step();
            chk_cnt++;
            if (out !== 4'h3 || out_valid !== 1'b1)
                $display("FAIL bp_hold[%0d]: got out=%h vld=%b want 3/1", k, out, out_valid);
            else pass_cnt++;
        end
        out_ready = 1'b1;
        a_valid   = 8'h10;
        #3;
        chk_cnt++;
        if (a_ready !== 8'h10) $display("FAIL bp_release_ready: got %b want %b", a_ready, 8'h10);
        else pass_cnt++;
        step();
        chk_cnt++;
        if (out !== 4'h5 || out_valid !== 1'b1 || out_sel !== 3'd4)
            $display("FAIL bp_reload: got out=%h vld=%b sel=%0d want 5/1/4", out, out_valid, out_sel);
        else pass_cnt++;
    endtask

    task automatic test_drain();
        apply_reset();
        set_counting_data();
        mode      = 1'b0;
        s         = 3'd1;
        a_valid   = '1;
        out_ready = 1'b1;
        step();
        chk_cnt++;
        if (out !== 4'h2 || out_valid !== 1'b1)
            $display("FAIL drain_load: got out=%h vld=%b want 2/1", out, out_valid);
        else pass_cnt++;
        a_valid = '0;
        #3;
        chk_cnt++;
        if (a_ready !== 8'h00) $display("FAIL drain_a_ready: got %b want %b", a_ready, 8'h00);
        else pass_cnt++;
        step();
        chk_cnt++;
        if (out_valid !== 1'b0 || out !== 4'h2 || out_sel !== 3'd1)
            $display("FAIL drain_empty: got vld=%b out=%h sel=%0d want 0/2/1", out_valid, out, out_sel);
        else pass_cnt++;
    endtask

    task automatic test_invalid_select();
        s5 = 3'd6;
        for (int k = 0; k < 3; k++) begin
            #3;
            chk_cnt++;
            if (ar5 !== 5'b00000) $display("FAIL inv_sel_ready[%0d]: got %b want %b", k, ar5, 5'b00000);
            else pass_cnt++;
            step();
            chk_cnt++;
            if (ov5 !== 1'b0) $display("FAIL inv_sel_valid[%0d]: got %b want 0", k, ov5);
            else pass_cnt++;
        end
        s5 = 3'd3;
        #3;
        chk_cnt++;
        if (ar5 !== 5'b01000) $display("FAIL n5_sel3_ready: got %b want %b", ar5, 5'b01000);
        else pass_cnt++;
        step();
        chk_cnt++;
        if (out5 !== 4'h4 || os5 !== 3'd3 || ov5 !== 1'b1)
            $display("FAIL n5_sel3_out: got out=%h sel=%0d vld=%b want 4/3/1", out5, os5, ov5);
        else pass_cnt++;
        s5 = 3'd6;
        step();
        chk_cnt++;
        if (ov5 !== 1'b0 || out5 !== 4'h4)
            $display("FAIL n5_inv_drain: got vld=%b out=%h want 0/4", ov5, out5);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        apply_reset();
        set_counting_data();
        mode      = 1'b0;
        s         = 3'd3;
        a_valid   = '1;
        out_ready = 1'b1;
        step();
        chk_cnt++;
        if (out !== 4'h4 || out_valid !== 1'b1 || out_sel !== 3'd3)
            $display("FAIL ar_setup: got out=%h vld=%b sel=%0d want 4/1/3", out, out_valid, out_sel);
        else pass_cnt++;
        #3;
        rst = 1'b1;
        #1;
        chk_cnt++;
        if (out !== 4'h0 || out_valid !== 1'b0 || out_sel !== 3'd0 || a_ready !== 8'h00)
            $display("FAIL ar_immediate: got out=%h vld=%b sel=%0d rdy=%b want 0/0/0/0",
                     out, out_valid, out_sel, a_ready);
        else pass_cnt++;
        @(posedge clk);
        #4;
        rst = 1'b0;
        model_reset();
        mode    = 1'b1;
        a_valid = '1;
        #1;
        chk_cnt++;
        if (a_ready !== 8'h01) $display("FAIL ar_first_grant_ready: got %b want %b", a_ready, 8'h01);
        else pass_cnt++;
        step();
        chk_cnt++;
        if (out_sel !== 3'd0 || out !== 4'h1 || out_valid !== 1'b1)
            $display("FAIL ar_first_grant: got sel=%0d out=%h vld=%b want 0/1/1", out_sel, out, out_valid);
        else pass_cnt++;
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            logic [N-1:0] er;
            mode      = 1'($urandom_range(0, 1));
            s         = SW'($urandom_range(0, N - 1));
            a_valid   = N'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            a         = $urandom;
            #3;
            er = exp_ready();
            chk_cnt++;
            if (a_ready !== er) $display("FAIL rand_ready[%0d]: got %b want %b", k, a_ready, er);
            else pass_cnt++;
            step();
            chk_cnt++;
            if (out_valid !== m_vld || out !== m_out || out_sel !== SW'(m_sel))
                $display("FAIL rand_out[%0d]: got vld=%b out=%h sel=%0d want %b/%h/%0d",
                         k, out_valid, out, out_sel, m_vld, m_out, m_sel);
            else pass_cnt++;
        end
    endtask

    initial begin
        rst       = 1'b1;
        a         = '0;
        a_valid   = '0;
        mode      = 1'b0;
        s         = '0;
        out_ready = 1'b1;
        mode5     = 1'b0;
        ordy5     = 1'b1;
        s5        = 3'd6;
        av5       = '1;
        for (int i = 0; i < N5; i++) a5[i*W +: W] = W'(i + 1);
        model_reset();

        test_reset();
        test_fixed_sweep();
        test_rr_fairness();
        test_backpressure();
        test_drain();
        test_invalid_select();
        test_async_reset();
        test_random();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/mux_arb_nx1.md
Name: mux_arb_nx1

Overview:
- Parametrised successor to the 8-to-1 selector.
- Selects one of N W-bit input channels and forwards it through a one-entry registered output stage with valid/ready handshakes on every channel.
- Two modes:
  - fixed: the channel is chosen by S, as in the combinational mux.
  - round-robin: fair arbitration across all valid channels.
- Sits between multiple producers and a single shared consumer in the datapath.

Parameters:
- W, 4, data width per channel.
- N, 8, number of input channels (N>=2; need not be a power of two).
- SW, $clog2(N), select/index width. Derived localparam, not overridable.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- A  in  N*W  flattened channel data; channel i occupies A[i*W +: W].
- A_VALID  in  N  per-channel valid.
- A_READY  out  N  per-channel ready; combinational, at most one bit set.
- MODE  in  1  0 = fixed select, 1 = round-robin.
- S  in  SW  channel index used in fixed mode.
- OUT  out  W  registered selected data.
- OUT_VALID  out  1  OUT holds a valid word.
- OUT_READY  in  1  consumer accepts OUT this cycle.
- OUT_SEL  out  SW  index of the channel that produced OUT.

Behaviour:
- Reset (RST high, asynchronous):
  - OUT=0, OUT_VALID=0, OUT_SEL=0.
  - Round-robin pointer PTR=N-1, so channel 0 has first priority after reset.
  - A_READY is forced to all-zero while RST is high.
- Output stage states:
  - EMPTY (OUT_VALID=0) and FULL (OUT_VALID=1).
  - load_en = !OUT_VALID || OUT_READY.
- Grant, combinational:
  - MODE=0: grant=S, gvalid=A_VALID[S]. If S>=N, gvalid=0 and nothing is granted.
  - MODE=1: grant = first i with A_VALID[i], searching PTR+1, PTR+2, ... modulo N (wraps N-1 -> 0). gvalid = |A_VALID.
- A_READY[grant] = load_en && gvalid. All other A_READY bits are 0.
- Transfer on channel g when A_VALID[g] && A_READY[g]. On that clock edge:
  - OUT <= channel g data, OUT_SEL <= g, OUT_VALID <= 1.
  - PTR <= g. PTR updates in both modes.
- Latency: an input accepted at edge k is visible on OUT at edge k, i.e. one register stage.
- Throughput: one word per cycle when OUT_READY is held high.
- FULL && OUT_READY && gvalid: drain and reload happen in the same cycle; OUT_VALID stays 1.
- FULL && OUT_READY && !gvalid: OUT_VALID <= 0. OUT and OUT_SEL hold their last values.
- FULL && !OUT_READY: OUT, OUT_SEL and OUT_VALID hold; all A_READY=0 (backpressure).
- EMPTY && !gvalid: no change.
- A MODE or S change applies to the next grant decision only. It never alters a word already in the output register.
- A_VALID from a non-granted channel must remain pending. The block does not drop it, and the producer holds its data until granted.
- Reset mid-transfer: the in-flight output word is discarded and PTR returns to N-1.

Decomposition:
- Package mux_arb_pkg:
  - MODE_FIXED=1'b0, MODE_RR=1'b1.
  - Function clog2 helper for SW.
- Sub-module rr_pick: purely combinational rotated priority encoder.
  - Params N, SW.
  - Inputs: req[N], ptr[SW].
  - Outputs: gnt_idx[SW], gnt_any.
- The top level holds the output register, PTR, the fixed/RR grant mux and the handshake logic.

Test Plan:
- Fixed sweep: W=4, N=8, channel i data = i+1, all A_VALID=1, OUT_READY=1, MODE=0, S stepped 0..7 (one per cycle).
  - Required: OUT = 1..8 with one-cycle lag, OUT_SEL = S of the previous cycle, A_READY = one-hot(S).
- Round-robin fairness: MODE=1, A_VALID=8'b1010_0101, OUT_READY=1 for 8 cycles after reset.
  - Required: OUT_SEL sequence 0,2,5,7,0,2,5,7; OUT sequence 1,3,6,8,1,3,6,8.
- Backpressure: FULL with OUT=4'h3; hold OUT_READY=0 for 3 cycles.
  - Required: OUT=3 and OUT_VALID=1 held; A_READY=0.
  - Then OUT_READY=1 with A_VALID[4]=1 in MODE=0, S=4: next OUT=5, no gap.
- Drain: single word accepted, then all A_VALID=0 with OUT_READY=1.
  - Required: OUT_VALID falls one cycle later; OUT holds its last value.
- Invalid select: parameter N=5, MODE=0, S=6, all valid.
  - Required: A_READY=0 and OUT_VALID stays 0.
- Async reset: assert RST between clock edges while OUT_VALID=1 and PTR=3.
  - Required: OUT=0, OUT_VALID=0, OUT_SEL=0 immediately.
  - After release in MODE=1 with all valid: first grant is channel 0.
